// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: bundles the requester handshake and the broadcast bus of the
// common data bus arbiter. The arbiter takes the slave view; the finishing
// sources and the bus consumers together take the master view.
interface cdb_arbiter_if #(
   parameter int NUM_REQ = 5,
   parameter int TAG_W   = 4,
   parameter int DATA_W  = 32
);
   localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic                      flush_i;
   logic [NUM_REQ-1:0]        req_valid_i;
   logic [NUM_REQ*TAG_W-1:0]  req_tag_i;
   logic [NUM_REQ*DATA_W-1:0] req_data_i;
   logic [NUM_REQ-1:0]        grant_o;
   logic                      cdb_valid_o;
   logic [TAG_W-1:0]          cdb_tag_o;
   logic [DATA_W-1:0]         cdb_data_o;
   logic [SRC_W-1:0]          cdb_src_o;

   modport master (
      output flush_i,
      output req_valid_i,
      output req_tag_i,
      output req_data_i,
      input  grant_o,
      input  cdb_valid_o,
      input  cdb_tag_o,
      input  cdb_data_o,
      input  cdb_src_o
   );

   modport slave (
      input  flush_i,
      input  req_valid_i,
      input  req_tag_i,
      input  req_data_i,
      output grant_o,
      output cdb_valid_o,
      output cdb_tag_o,
      output cdb_data_o,
      output cdb_src_o
   );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants the common data bus to at most one finished source per
// cycle and broadcasts the winner's ROB tag and result one cycle later.
// Fixed-priority sources (PRIO_MASK) beat round-robin sources, except that a
// round-robin source that has waited STARVE_LIM cycles is forced through.
module cdb_arbiter #(
   parameter int                 NUM_REQ    = 5,
   parameter int                 TAG_W      = 4,
   parameter int                 DATA_W     = 32,
   parameter logic [NUM_REQ-1:0] PRIO_MASK  = 5'b10000,
   parameter int                 STARVE_LIM = 4
) (
   input  logic         clk_i,
   input  logic         reset_n_i,
   cdb_arbiter_if.slave bus
);
   localparam int               SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int               CNT_W    = 3;
   localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(STARVE_LIM);
   localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);

   // arbitration state
   logic [SRC_W-1:0]  rr_ptr;
   logic [CNT_W-1:0]  wait_cnt [NUM_REQ];

   // per-rule candidates
   logic              starve_hit;
   logic [SRC_W-1:0]  starve_idx;
   logic              prio_hit;
   logic [SRC_W-1:0]  prio_idx;
   logic              rr_hit;
   logic [SRC_W-1:0]  rr_idx;
   logic [SRC_W-1:0]  scan_idx;
   int                scan_pos;

   // winner and handshake
   logic              win_valid;
   logic [SRC_W-1:0]  win_idx;
   logic [NUM_REQ-1:0] grant;
   logic              handshake;
   logic              win_is_rr;
   logic [SRC_W-1:0]  rr_next;
   logic [TAG_W-1:0]  win_tag;
   logic [DATA_W-1:0] win_data;

   // broadcast registers
   logic              cdb_valid_q;
   logic [TAG_W-1:0]  cdb_tag_q;
   logic [DATA_W-1:0] cdb_data_q;
   logic [SRC_W-1:0]  cdb_src_q;

   // Lowest-index round-robin source whose wait counter has saturated.
   always_comb begin
      starve_hit = 1'b0;
      starve_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!starve_hit && bus.req_valid_i[i] && !PRIO_MASK[i] &&
             (wait_cnt[i] == CNT_LIM)) begin
            starve_hit = 1'b1;
            starve_idx = SRC_W'(i);
         end
      end
   end

   // Lowest-index valid fixed-priority source.
   always_comb begin
      prio_hit = 1'b0;
      prio_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!prio_hit && bus.req_valid_i[i] && PRIO_MASK[i]) begin
            prio_hit = 1'b1;
            prio_idx = SRC_W'(i);
         end
      end
   end

   // First valid round-robin source scanning upward from rr_ptr with wrap.
   always_comb begin
      rr_hit   = 1'b0;
      rr_idx   = '0;
      scan_pos = 0;
      scan_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_pos = int'(rr_ptr) + k;
         if (scan_pos >= NUM_REQ) begin
            scan_pos = scan_pos - NUM_REQ;
         end
         scan_idx = SRC_W'(scan_pos);
         if (!rr_hit && bus.req_valid_i[scan_idx] && !PRIO_MASK[scan_idx]) begin
            rr_hit = 1'b1;
            rr_idx = scan_idx;
         end
      end
   end

   // Starvation beats fixed priority, which beats plain round-robin.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      if (starve_hit) begin
         win_valid = 1'b1;
         win_idx   = starve_idx;
      end else if (prio_hit) begin
         win_valid = 1'b1;
         win_idx   = prio_idx;
      end else if (rr_hit) begin
         win_valid = 1'b1;
         win_idx   = rr_idx;
      end
   end

   // One-hot grant, suppressed during reset and on a flush.
   always_comb begin
      grant = '0;
      if (reset_n_i && !bus.flush_i && win_valid) begin
         grant[win_idx] = 1'b1;
      end
   end

   assign handshake = |(grant & bus.req_valid_i);
   assign win_is_rr = !PRIO_MASK[win_idx];
   assign rr_next   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
   assign win_tag   = bus.req_tag_i[int'(win_idx)*TAG_W +: TAG_W];
   assign win_data  = bus.req_data_i[int'(win_idx)*DATA_W +: DATA_W];

   // Round-robin pointer moves past any non-priority winner, starved or not.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rr_ptr <= '0;
      end else if (bus.flush_i) begin
         rr_ptr <= '0;
      end else if (handshake && win_is_rr) begin
         rr_ptr <= rr_next;
      end
   end

   // Saturating wait counters for round-robin sources that are held off.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            wait_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.flush_i || PRIO_MASK[i] || !bus.req_valid_i[i] || grant[i]) begin
               wait_cnt[i] <= '0;
            end else if (wait_cnt[i] != CNT_LIM) begin
               wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Broadcast register: valid pulses per handshake, payload holds otherwise.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_data_q  <= '0;
         cdb_src_q   <= '0;
      end else begin
         cdb_valid_q <= handshake;
         if (handshake) begin
            cdb_tag_q  <= win_tag;
            cdb_data_q <= win_data;
            cdb_src_q  <= win_idx;
         end
      end
   end

   assign bus.grant_o     = grant;
   assign bus.cdb_valid_o = cdb_valid_q;
   assign bus.cdb_tag_o   = cdb_tag_q;
   assign bus.cdb_data_o  = cdb_data_q;
   assign bus.cdb_src_o   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios followed by randomized requester traffic,
// all checked against a behavioural model of the bus arbitration rules.
module tb_cdb_arbiter;
   localparam int                 NUM_REQ    = 5;
   localparam int                 TAG_W      = 4;
   localparam int                 DATA_W     = 32;
   localparam logic [NUM_REQ-1:0] PRIO_MASK  = 5'b10000;
   localparam int                 STARVE_LIM = 4;
   localparam int                 SRC_W      = $clog2(NUM_REQ);

   logic clk_i     = 1'b0;
   logic reset_n_i = 1'b0;

   // free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk_i = ~clk_i;

   cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

   cdb_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .TAG_W     (TAG_W),
      .DATA_W    (DATA_W),
      .PRIO_MASK (PRIO_MASK),
      .STARVE_LIM(STARVE_LIM)
   ) dut (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .bus      (bus)
   );

   // requester-side stimulus
   logic [NUM_REQ-1:0] r_valid;
   logic               r_flush;
   logic [TAG_W-1:0]   r_tag  [NUM_REQ];
   logic [DATA_W-1:0]  r_data [NUM_REQ];

   // reference model: age = cycles a round-robin source has been held off
   int                 m_age [NUM_REQ];
   int                 m_rr;
   logic               m_valid;
   logic [TAG_W-1:0]   m_tag;
   logic [DATA_W-1:0]  m_data;
   logic [SRC_W-1:0]   m_src;

   int                 exp_grant;
   logic [NUM_REQ-1:0] obs_grant;
   int                 vectors     = 0;
   int                 miscompares = 0;
   int                 t3_seq [10] = '{4, 4, 4, 4, 2, 4, 4, 4, 4, 2};

   task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic apply_stimulus();
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_tag_i[i*TAG_W +: TAG_W]    = r_tag[i];
         bus.req_data_i[i*DATA_W +: DATA_W] = r_data[i];
      end
      bus.req_valid_i = r_valid;
      bus.flush_i     = r_flush;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_REQ; i++) m_age[i] = 0;
      m_rr    = 0;
      m_valid = 1'b0;
      m_tag   = '0;
      m_data  = '0;
      m_src   = '0;
   endtask

   // winner index by the arbitration rules, -1 when nobody may win
   function automatic int model_pick();
      if (r_flush) return -1;
      for (int i = 0; i < NUM_REQ; i++)
         if (r_valid[i] && !PRIO_MASK[i] && m_age[i] >= STARVE_LIM) return i;
      for (int i = 0; i < NUM_REQ; i++)
         if (r_valid[i] && PRIO_MASK[i]) return i;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = (m_rr + k) % NUM_REQ;
         if (r_valid[idx] && !PRIO_MASK[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_update(input int g);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!PRIO_MASK[i] && !r_flush && r_valid[i] && g != i) m_age[i] = m_age[i] + 1;
         else m_age[i] = 0;
      end
      if (r_flush) m_rr = 0;
      else if (g >= 0 && !PRIO_MASK[g]) m_rr = (g + 1) % NUM_REQ;
      if (g >= 0) begin
         m_valid = 1'b1;
         m_tag   = r_tag[g];
         m_data  = r_data[g];
         m_src   = SRC_W'(g);
      end else begin
         m_valid = 1'b0;
      end
   endtask

   // one clock: drive, check grant before the edge, check broadcast after it
   task automatic run_cycle(input string name);
      logic [NUM_REQ-1:0] exp_vec;
      apply_stimulus();
      #1;
      exp_grant = model_pick();
      exp_vec   = '0;
      if (exp_grant >= 0) exp_vec[exp_grant] = 1'b1;
      obs_grant = bus.grant_o;
      check_output({name, ".grant"}, 64'(obs_grant), 64'(exp_vec));
      @(posedge clk_i);
      model_update(exp_grant);
      #1;
      check_output({name, ".cdb_valid"}, 64'(bus.cdb_valid_o), 64'(m_valid));
      check_output({name, ".cdb_tag"},   64'(bus.cdb_tag_o),   64'(m_tag));
      check_output({name, ".cdb_data"},  64'(bus.cdb_data_o),  64'(m_data));
      check_output({name, ".cdb_src"},   64'(bus.cdb_src_o),   64'(m_src));
      @(negedge clk_i);
   endtask

   initial begin
      // test 1: reset with idle and with active requesters
      r_valid = '0;
      r_flush = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         r_tag[i]  = '0;
         r_data[i] = '0;
      end
      model_reset();
      apply_stimulus();
      #2;
      check_output("t1.rst_grant", 64'(bus.grant_o), 64'd0);
      check_output("t1.rst_valid", 64'(bus.cdb_valid_o), 64'd0);
      r_valid = 5'b10101;
      apply_stimulus();
      #1;
      check_output("t1.rst_grant_busy", 64'(bus.grant_o), 64'd0);
      r_valid = '0;
      apply_stimulus();
      @(negedge clk_i);
      reset_n_i = 1'b1;
      run_cycle("t1.idle0");
      run_cycle("t1.idle1");

      // test 2: four round-robin sources held valid rotate with no gaps
      for (int i = 0; i < 4; i++) begin
         r_tag[i]  = TAG_W'(i + 1);
         r_data[i] = 32'h100 + 32'(i);
      end
      r_valid = 5'b01111;
      for (int k = 0; k < 8; k++) begin
         run_cycle("t2");
         check_output("t2.grant_seq", 64'(obs_grant), 64'(1) << (k % 4));
         check_output("t2.tag_seq", 64'(bus.cdb_tag_o), 64'(k % 4 + 1));
      end
      r_valid = '0;
      run_cycle("t2.drain");
      run_cycle("t2.idle");

      // test 3: priority source dominates until the waiter starves
      r_tag[4]  = 4'd9;
      r_data[4] = 32'hCAFE_0004;
      r_tag[2]  = 4'd5;
      r_data[2] = 32'hCAFE_0002;
      r_valid   = 5'b10100;
      for (int k = 0; k < 10; k++) begin
         run_cycle("t3");
         check_output("t3.grant_seq", 64'(obs_grant), 64'(1) << t3_seq[k]);
      end
      r_valid = '0;
      run_cycle("t3.drain");

      // test 4: single broadcast, latency one, payload holds afterwards
      r_tag[1]  = 4'd7;
      r_data[1] = 32'hDEAD_BEEF;
      r_valid   = 5'b00010;
      run_cycle("t4.req");
      check_output("t4.valid", 64'(bus.cdb_valid_o), 64'd1);
      check_output("t4.tag",   64'(bus.cdb_tag_o),   64'd7);
      check_output("t4.data",  64'(bus.cdb_data_o),  64'hDEAD_BEEF);
      check_output("t4.src",   64'(bus.cdb_src_o),   64'd1);
      r_valid = '0;
      run_cycle("t4.idle");
      check_output("t4.valid_drop", 64'(bus.cdb_valid_o), 64'd0);
      check_output("t4.tag_hold",   64'(bus.cdb_tag_o),   64'd7);

      // test 5: flush blocks the grant and rewinds the round-robin pointer
      r_valid = 5'b01001;
      r_flush = 1'b1;
      run_cycle("t5.flush");
      check_output("t5.flush_grant", 64'(obs_grant), 64'd0);
      check_output("t5.flush_valid", 64'(bus.cdb_valid_o), 64'd0);
      r_flush = 1'b0;
      run_cycle("t5.after0");
      check_output("t5.grant_req0", 64'(obs_grant), 64'b00001);
      run_cycle("t5.after1");
      check_output("t5.grant_req3", 64'(obs_grant), 64'b01000);
      r_valid = '0;
      run_cycle("t5.idle");

      // test 6: asynchronous reset while broadcasting clears all state
      r_valid = 5'b00100;
      run_cycle("t6.pre_rr");
      check_output("t6.pre_grant2", 64'(obs_grant), 64'b00100);
      r_valid = 5'b10100;
      for (int k = 0; k < 3; k++) run_cycle("t6.pre_prio");
      check_output("t6.pre_valid", 64'(bus.cdb_valid_o), 64'd1);
      reset_n_i = 1'b0;
      #1;
      check_output("t6.async_valid", 64'(bus.cdb_valid_o), 64'd0);
      check_output("t6.async_grant", 64'(bus.grant_o),     64'd0);
      check_output("t6.async_tag",   64'(bus.cdb_tag_o),   64'd0);
      check_output("t6.async_data",  64'(bus.cdb_data_o),  64'd0);
      check_output("t6.async_src",   64'(bus.cdb_src_o),   64'd0);
      model_reset();
      @(posedge clk_i);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      r_valid = 5'b01110;
      run_cycle("t6.rr_cleared");
      check_output("t6.rr_grant1", 64'(obs_grant), 64'b00010);
      r_valid = 5'b10100;
      for (int k = 0; k < 4; k++) begin
         run_cycle("t6.cnt_cleared");
         check_output("t6.cnt_grant", 64'(obs_grant), (k < 3) ? 64'b10000 : 64'b00100);
      end
      r_valid = '0;
      run_cycle("t6.idle");

      // randomized traffic: requesters hold results until granted
      for (int n = 0; n < 400; n++) begin
         run_cycle("rand");
         for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_grant == i) begin
               if ($urandom_range(0, 9) < (PRIO_MASK[i] ? 7 : 3)) begin
                  r_tag[i]  = TAG_W'($urandom);
                  r_data[i] = $urandom;
               end else begin
                  r_valid[i] = 1'b0;
               end
            end else if (!r_valid[i] && $urandom_range(0, 1) == 1) begin
               r_valid[i] = 1'b1;
               r_tag[i]   = TAG_W'($urandom);
               r_data[i]  = $urandom;
            end
         end
         r_flush = ($urandom_range(0, 15) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
